mem_port_arbiter: RTL and testbench

//  Shares one 64-bit data-memory port between instruction fetch (IF) and the load/store unit (LS).

---
 rtl/mem_port_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch and load/store
// LS wins ties unless IF has waited through STARVE_LIM consecutive LS grants.
module mem_port_arbiter #(
  parameter int XLEN       = 64,
  parameter int STARVE_LIM = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req_valid,
  output logic            if_req_ready,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_rsp_valid,
  output logic [31:0]     if_rdata,
  input  logic            ls_req_valid,
  output logic            ls_req_ready,
  input  logic            ls_we,
  input  logic [XLEN-1:0] ls_addr,
  input  logic [XLEN-1:0] ls_wdata,
  input  logic [7:0]      ls_wstrb,
  output logic            ls_rsp_valid,
  output logic [XLEN-1:0] ls_rdata,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [7:0]      mem_wstrb,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            busy,
  output logic            spurious_rsp
);

  typedef enum logic [2:0] {IDLE, REQ_IF, REQ_LS, WAIT_IF, WAIT_LS} state_t;

  localparam int CW = $clog2(STARVE_LIM + 1);

  state_t          state, state_nxt;
  logic [CW-1:0]   starve_cnt;
  logic            starve_hit;
  logic            if_hi;

  assign starve_hit = (starve_cnt == CW'(STARVE_LIM));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ls_req_ready) state_nxt = REQ_LS;
               else if (if_req_ready) state_nxt = REQ_IF;
      REQ_IF:  if (mem_req_ready) state_nxt = WAIT_IF;
      REQ_LS:  if (mem_req_ready) state_nxt = WAIT_LS;
      WAIT_IF: if (mem_rsp_valid) state_nxt = IDLE;
      WAIT_LS: if (mem_rsp_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ls_req_ready  = 1'b0;
    if_req_ready  = 1'b0;
    mem_req_valid = 1'b0;
    busy          = (state != IDLE);
    case (state)
      IDLE: begin
        ls_req_ready = ls_req_valid & ~(if_req_valid & starve_hit);
        if_req_ready = if_req_valid & ~ls_req_ready;
      end
      REQ_IF, REQ_LS: mem_req_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wstrb    <= '0;
      if_hi        <= 1'b0;
      starve_cnt   <= '0;
      if_rsp_valid <= 1'b0;
      ls_rsp_valid <= 1'b0;
      if_rdata     <= '0;
      ls_rdata     <= '0;
      spurious_rsp <= 1'b0;
    end else begin
      if_rsp_valid <= 1'b0;
      ls_rsp_valid <= 1'b0;
      if (ls_req_ready) begin
        mem_we    <= ls_we;
        mem_addr  <= ls_addr;
        mem_wdata <= ls_wdata;
        mem_wstrb <= ls_wstrb;
        if (!if_req_valid)   starve_cnt <= '0;
        else if (!starve_hit) starve_cnt <= starve_cnt + 1'b1;
      end else if (if_req_ready) begin
        mem_we     <= 1'b0;
        mem_addr   <= {if_addr[XLEN-1:3], 3'b000};
        mem_wdata  <= '0;
        mem_wstrb  <= '0;
        if_hi      <= if_addr[2];
        starve_cnt <= '0;
      end
      // Responses only count while a transaction is waiting for one.
      if (state == WAIT_IF && mem_rsp_valid) begin
        if_rsp_valid <= 1'b1;
        if_rdata     <= if_hi ? mem_rdata[63:32] : mem_rdata[31:0];
      end
      if (state == WAIT_LS && mem_rsp_valid) begin
        ls_rsp_valid <= 1'b1;
        ls_rdata     <= mem_we ? '0 : mem_rdata;
      end
      if (mem_rsp_valid && state != WAIT_IF && state != WAIT_LS)
        spurious_rsp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int XLEN = 64;
  localparam int LIM  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic if_req_valid = 0, if_req_ready, if_rsp_valid;
  logic [63:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic ls_req_valid = 0, ls_req_ready, ls_we = 0, ls_rsp_valid;
  logic [63:0] ls_addr = '0, ls_wdata = '0, ls_rdata;
  logic [7:0] ls_wstrb = '0;
  logic mem_req_valid, mem_req_ready = 0, mem_we, mem_rsp_valid = 0;
  logic [63:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic [7:0] mem_wstrb;
  logic busy, spurious_rsp;

  always #5 clk = ~clk;

  mem_port_arbiter #(.XLEN(XLEN), .STARVE_LIM(LIM)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_we(ls_we),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_wstrb(ls_wstrb),
    .ls_rsp_valid(ls_rsp_valid), .ls_rdata(ls_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .busy(busy), .spurious_rsp(spurious_rsp)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction-level reference: one outstanding transaction, tracked by side and phase.
  logic        m_busy = 0, m_sent = 0, m_side_ls = 0, m_ifhi = 0;
  logic        m_we = 0, m_if_rsp = 0, m_ls_rsp = 0, m_spur = 0;
  logic [63:0] m_addr = '0, m_wdata = '0, m_ls_rdata = '0;
  logic [31:0] m_if_rdata = '0;
  logic [7:0]  m_wstrb = '0;
  int          m_starve = 0;
  logic        e_ls_ready, e_if_ready;

  assign e_ls_ready = !m_busy && ls_req_valid && !(if_req_valid && m_starve == LIM);
  assign e_if_ready = !m_busy && if_req_valid && !e_ls_ready;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 0; m_sent <= 0; m_side_ls <= 0; m_ifhi <= 0; m_we <= 0;
      m_if_rsp <= 0; m_ls_rsp <= 0; m_spur <= 0; m_addr <= '0; m_wdata <= '0;
      m_wstrb <= '0; m_ls_rdata <= '0; m_if_rdata <= '0; m_starve <= 0;
    end else begin
      m_if_rsp <= 0;
      m_ls_rsp <= 0;
      if (m_busy && m_sent && mem_rsp_valid) begin
        m_busy <= 0;
        if (m_side_ls) begin
          m_ls_rsp   <= 1;
          m_ls_rdata <= m_we ? 64'd0 : mem_rdata;
        end else begin
          m_if_rsp   <= 1;
          m_if_rdata <= m_ifhi ? mem_rdata[63:32] : mem_rdata[31:0];
        end
      end else if (mem_rsp_valid) begin
        m_spur <= 1;
      end
      if (m_busy && !m_sent && mem_req_ready) m_sent <= 1;
      if (e_ls_ready) begin
        m_busy <= 1; m_sent <= 0; m_side_ls <= 1;
        m_we <= ls_we; m_addr <= ls_addr; m_wdata <= ls_wdata; m_wstrb <= ls_wstrb;
        m_starve <= if_req_valid ? ((m_starve < LIM) ? m_starve + 1 : LIM) : 0;
      end else if (e_if_ready) begin
        m_busy <= 1; m_sent <= 0; m_side_ls <= 0; m_ifhi <= if_addr[2];
        m_we <= 0; m_addr <= {if_addr[63:3], 3'b000}; m_wdata <= '0; m_wstrb <= '0;
        m_starve <= 0;
      end
    end
  end

  // Event log and counters used by the literal expectations.
  int    cyc = 0, if_acc_cyc = 0, if_rsp_cyc = 0;
  int    if_pulses = 0, ls_pulses = 0, req_cycles = 0;
  logic [63:0] last_req_addr = '0;
  string glog = "";

  always @(posedge clk) begin
    if (if_req_valid && if_req_ready) begin glog = {glog, "I"}; if_acc_cyc = cyc; end
    if (ls_req_valid && ls_req_ready) glog = {glog, "L"};
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    chk("if_req_ready", if_req_ready, e_if_ready);
    chk("ls_req_ready", ls_req_ready, e_ls_ready);
    chk("mem_req_valid", mem_req_valid, m_busy && !m_sent);
    chk("busy", busy, m_busy);
    chk("mem_we", mem_we, m_we);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("mem_wstrb", mem_wstrb, m_wstrb);
    chk("if_rsp_valid", if_rsp_valid, m_if_rsp);
    chk("ls_rsp_valid", ls_rsp_valid, m_ls_rsp);
    chk("if_rdata", if_rdata, m_if_rdata);
    chk("ls_rdata", ls_rdata, m_ls_rdata);
    chk("spurious_rsp", spurious_rsp, m_spur);
    if (mem_req_valid) begin req_cycles = req_cycles + 1; last_req_addr = mem_addr; end
    if (if_rsp_valid) begin if_pulses = if_pulses + 1; if_rsp_cyc = cyc; end
    if (ls_rsp_valid) ls_pulses = ls_pulses + 1;
  end

  task automatic if_req(input logic [63:0] a);
    int n = 0;
    if_addr = a; if_req_valid = 1;
    do begin @(negedge clk); n++; end while (!if_req_ready && n < 200);
    if (!if_req_ready) begin checks++; errors++; $display("FAIL if_req_timeout: got no ready expected ready"); end
    @(posedge clk); #1 if_req_valid = 0;
  endtask

  task automatic ls_req(input logic we, input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
    int n = 0;
    ls_we = we; ls_addr = a; ls_wdata = d; ls_wstrb = s; ls_req_valid = 1;
    do begin @(negedge clk); n++; end while (!ls_req_ready && n < 200);
    if (!ls_req_ready) begin checks++; errors++; $display("FAIL ls_req_timeout: got no ready expected ready"); end
    @(posedge clk); #1 ls_req_valid = 0;
  endtask

  task automatic serve(input int rdy_wait, input logic [63:0] data);
    int n = 0;
    while (!mem_req_valid && n < 200) begin @(posedge clk); #1; n++; end
    if (!mem_req_valid) begin
      checks++; errors++; $display("FAIL serve_timeout: got no mem_req_valid expected request");
    end else begin
      repeat (rdy_wait) begin @(posedge clk); #1; end
      mem_req_ready = 1;
      @(posedge clk); #1 mem_req_ready = 0;
      mem_rsp_valid = 1; mem_rdata = data;
      @(posedge clk); #1 mem_rsp_valid = 0;
    end
  endtask

  initial begin
    int ls_before;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_spurious", spurious_rsp, 0);
    rst = 0;
    repeat (2) @(posedge clk);
    #1;

    // T6: stray response in IDLE
    mem_rsp_valid = 1; mem_rdata = 64'h0123_4567_89AB_CDEF;
    @(posedge clk); #1 mem_rsp_valid = 0;
    chk("t6_spurious_set", spurious_rsp, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_spurious_sticky", spurious_rsp, 1);
    chk("t6_no_if_pulse", if_pulses, 0);
    chk("t6_no_ls_pulse", ls_pulses, 0);

    // T1: IF alone
    fork
      if_req(64'h8000_0004);
      serve(0, 64'h1111_2222_3333_4444);
    join
    chk("t1_mem_addr", last_req_addr, 64'h8000_0000);
    chk("t1_if_rdata", if_rdata, 64'h1111_2222);
    chk("t1_pulse_now", if_rsp_valid, 1);
    @(posedge clk); #1;
    chk("t1_pulse_gone", if_rsp_valid, 0);
    chk("t1_pulse_count", if_pulses, 1);
    chk("t1_latency", if_rsp_cyc - if_acc_cyc, 3);

    // T2: simultaneous requests, LS first
    glog = "";
    fork
      ls_req(0, 64'h200, 64'd0, 8'h00);
      if_req(64'h8000_0010);
      begin serve(0, 64'hAAAA_BBBB_CCCC_DDDD); serve(0, 64'h5555_6666_7777_8888); end
    join
    chk("t2_order", (glog == "LI"), 1);
    chk("t2_ls_rdata", ls_rdata, 64'hAAAA_BBBB_CCCC_DDDD);
    chk("t2_if_rdata", if_rdata, 64'h7777_8888);
    repeat (2) @(posedge clk);
    #1;

    // T3: starvation bound
    glog = "";
    fork
      for (int k = 0; k < 5; k++) ls_req(0, 64'h400 + 64'(k * 8), 64'd0, 8'h00);
      if_req(64'h8000_0104);
      for (int k = 0; k < 6; k++) serve(0, {32'h5A5A_0000 + 32'(k), 32'h0000_1000 + 32'(k)});
    join
    chk("t3_order", (glog == "LLLLIL"), 1);
    if (glog != "LLLLIL") $display("  grant sequence was %s", glog);
    chk("t3_if_rdata", if_rdata, 64'h5A5A_0004);
    chk("t3_ls_rdata", ls_rdata, 64'h5A5A_0005_0000_1005);
    repeat (2) @(posedge clk);
    #1;

    // T4: store with mem_req_ready held low
    req_cycles = 0;
    fork
      ls_req(1, 64'h100, 64'hDEAD_BEEF_0000_00AA, 8'h01);
      serve(5, 64'hFFFF_FFFF_FFFF_FFFF);
    join
    chk("t4_req_cycles", req_cycles, 6);
    chk("t4_addr", last_req_addr, 64'h100);
    chk("t4_ls_rsp", ls_rsp_valid, 1);
    chk("t4_ls_rdata", ls_rdata, 0);
    repeat (2) @(posedge clk);
    #1;

    // T5: reset while waiting for the load response
    fork
      ls_req(0, 64'h300, 64'd0, 8'h00);
      begin
        int n = 0;
        while (!mem_req_valid && n < 200) begin @(posedge clk); #1; n++; end
        mem_req_ready = 1;
        @(posedge clk); #1 mem_req_ready = 0;
      end
    join
    @(posedge clk); #1;
    chk("t5_busy_before", busy, 1);
    ls_before = ls_pulses;
    rst = 1;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_mem_addr", mem_addr, 0);
    chk("t5_if_rdata", if_rdata, 0);
    chk("t5_ls_rdata", ls_rdata, 0);
    chk("t5_spurious_clr", spurious_rsp, 0);
    @(posedge clk); #1 rst = 0;
    mem_rsp_valid = 1; mem_rdata = 64'hCAFE_F00D_CAFE_F00D;
    @(posedge clk); #1 mem_rsp_valid = 0;
    @(posedge clk); #1;
    chk("t5_spurious", spurious_rsp, 1);
    chk("t5_no_ls_rsp", ls_pulses - ls_before, 0);
    chk("t5_ls_rdata_after", ls_rdata, 0);

    rst = 1;
    @(posedge clk); #1;
    chk("final_spurious_clr", spurious_rsp, 0);
    rst = 0;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
